// File: rtl/aes_seq_ctrl_if.sv
// Bundles the host-side register port and the core-side key/data/result
// buses of the AES sequencer. The slave modport is the sequencer's view.
interface aes_seq_ctrl_if;
  logic        WR_EN;
  logic [2:0]  WR_ADDR;
  logic [31:0] WR_DATA;
  logic        START;
  logic        KEY_LOAD;
  logic        CLR_DONE;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [31:0] RES0, RES1, RES2, RES3;
  logic [31:0] IN_DATA0, IN_DATA1, IN_DATA2, IN_DATA3;
  logic [31:0] IN_KEY0, IN_KEY1, IN_KEY2, IN_KEY3;
  logic        Krdy;
  logic        Drdy;
  logic        EN;
  logic        BSY;
  logic [31:0] OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3;

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, START, KEY_LOAD, CLR_DONE,
    output BUSY, DONE, ERR, RES0, RES1, RES2, RES3,
    output IN_DATA0, IN_DATA1, IN_DATA2, IN_DATA3,
    output IN_KEY0, IN_KEY1, IN_KEY2, IN_KEY3,
    output Krdy, Drdy, EN,
    input  BSY, OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3
  );

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, START, KEY_LOAD, CLR_DONE,
    input  BUSY, DONE, ERR, RES0, RES1, RES2, RES3,
    input  IN_DATA0, IN_DATA1, IN_DATA2, IN_DATA3,
    input  IN_KEY0, IN_KEY1, IN_KEY2, IN_KEY3,
    input  Krdy, Drdy, EN,
    output BSY, OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3
  );
endinterface

// File: rtl/aes_seq_ctrl.sv
// Host-side sequencer for the 32-bit-split AES core wrapper: loads key/data
// words, pulses Krdy/Drdy, waits out BSY and latches the result with a sticky
// DONE. Optional wait-state timeout with ERR when AES_SEQ_TIMEOUT_EN is defined.
module aes_seq_ctrl #(
  parameter int BSY_GUARD = 1
`ifdef AES_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic          CLK,
  input  logic          RSTn,
  aes_seq_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KREQ  = 3'd1;
  localparam logic [2:0] S_KWAIT = 3'd2;
  localparam logic [2:0] S_DREQ  = 3'd3;
  localparam logic [2:0] S_DWAIT = 3'd4;
  localparam logic [2:0] S_CAP   = 3'd5;

  localparam logic [2:0] GUARD_INIT = 3'(BSY_GUARD);

  logic [2:0]  state_q, state_d;
  logic [2:0]  guard_q, guard_d;
  logic        kvalid_q, kvalid_d;
  logic        done_q, done_d;
  logic        en_q;
  logic [31:0] data_q [4];
  logic [31:0] key_q  [4];
  logic [31:0] res_q  [4];

  logic wr_acc, key_wr, kvalid_eff, cap;

  assign wr_acc     = bus.WR_EN && (state_q == S_IDLE);
  assign key_wr     = wr_acc && bus.WR_ADDR[2];
  // A key write landing with START must force a fresh key schedule.
  assign kvalid_eff = kvalid_q && !key_wr;
  assign cap        = (state_q == S_CAP);

`ifdef AES_SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wcnt_q, wcnt_d;
  logic        err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    kvalid_d = kvalid_q;
    done_d   = done_q;
`ifdef AES_SEQ_TIMEOUT_EN
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    if (bus.CLR_DONE) err_d = 1'b0;
`endif
    if (bus.CLR_DONE) done_d = 1'b0;
    if (key_wr) kvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          done_d  = 1'b0;
          state_d = (bus.KEY_LOAD || !kvalid_eff) ? S_KREQ : S_DREQ;
        end
      end
      S_KREQ: begin
        guard_d = GUARD_INIT;
        state_d = S_KWAIT;
      end
      S_KWAIT: begin
        if (guard_q != 3'd0) begin
          guard_d = guard_q - 3'd1;
        end else if (!bus.BSY) begin
          kvalid_d = 1'b1;
          state_d  = S_DREQ;
        end
      end
      S_DREQ: begin
        guard_d = GUARD_INIT;
        state_d = S_DWAIT;
      end
      S_DWAIT: begin
        if (guard_q != 3'd0) begin
          guard_d = guard_q - 3'd1;
        end else if (!bus.BSY) begin
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AES_SEQ_TIMEOUT_EN
    // Counter restarts on each wait-state entry; a normal exit beats the limit.
    if (state_q == S_KREQ || state_q == S_DREQ) begin
      wcnt_d = 16'd0;
    end else if ((state_q == S_KWAIT || state_q == S_DWAIT) && state_d == state_q) begin
      if (wcnt_q == TO_LAST) begin
        err_d    = 1'b1;
        kvalid_d = 1'b0;
        state_d  = S_IDLE;
      end else begin
        wcnt_d = wcnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      guard_q  <= 3'd0;
      kvalid_q <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
      wcnt_q   <= 16'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      kvalid_q <= kvalid_d;
      done_q   <= done_d;
      en_q     <= 1'b1;
`ifdef AES_SEQ_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= 32'd0;
        key_q[i]  <= 32'd0;
        res_q[i]  <= 32'd0;
      end
    end else begin
      if (wr_acc) begin
        if (bus.WR_ADDR[2]) key_q[bus.WR_ADDR[1:0]]  <= bus.WR_DATA;
        else                data_q[bus.WR_ADDR[1:0]] <= bus.WR_DATA;
      end
      if (cap) begin
        res_q[0] <= bus.OUT_DATA0;
        res_q[1] <= bus.OUT_DATA1;
        res_q[2] <= bus.OUT_DATA2;
        res_q[3] <= bus.OUT_DATA3;
      end
    end
  end

  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.DONE     = done_q;
`ifdef AES_SEQ_TIMEOUT_EN
  assign bus.ERR      = err_q;
`else
  assign bus.ERR      = 1'b0;
`endif
  assign bus.Krdy     = (state_q == S_KREQ);
  assign bus.Drdy     = (state_q == S_DREQ);
  assign bus.EN       = en_q;
  assign bus.RES0     = res_q[0];
  assign bus.RES1     = res_q[1];
  assign bus.RES2     = res_q[2];
  assign bus.RES3     = res_q[3];
  assign bus.IN_DATA0 = data_q[0];
  assign bus.IN_DATA1 = data_q[1];
  assign bus.IN_DATA2 = data_q[2];
  assign bus.IN_DATA3 = data_q[3];
  assign bus.IN_KEY0  = key_q[0];
  assign bus.IN_KEY1  = key_q[1];
  assign bus.IN_KEY2  = key_q[2];
  assign bus.IN_KEY3  = key_q[3];

endmodule

// File: doc/aes_seq_ctrl.md
Name: aes_seq_ctrl

Overview:
- Host-side sequencer that sits directly upstream of the 32-bit-split AES core wrapper.
- Accepts 32-bit register writes for key and plaintext words.
- Drives the wrapper's key/data buses and issues the Krdy/Drdy pulses in the correct order.
- Waits out BSY, then captures the 128-bit result into stable output registers with a sticky DONE flag for an AXI-lite slave to poll.

Parameters:
- BSY_GUARD, 1: cycles after a Krdy/Drdy pulse during which BSY is ignored (core BSY rise latency); range 1-7.
- TIMEOUT_CYCLES, 1024: max cycles spent in any wait state before ERR (only with the optional feature).

Ports:
- CLK  in  1  system clock
- RSTn  in  1  asynchronous active-low reset
- WR_EN  in  1  host word write strobe
- WR_ADDR  in  3  0-3 = data word 0-3, 4-7 = key word 0-3
- WR_DATA  in  32  write data
- START  in  1  one-cycle start pulse
- KEY_LOAD  in  1  sampled with START; 1 = run key schedule before data
- CLR_DONE  in  1  clears DONE and ERR
- BUSY  out  1  sequencer not IDLE
- DONE  out  1  sticky, result valid
- ERR  out  1  sticky, timeout occurred
- RES0..RES3  out  32 each  captured result words (RES3 = MSW)
- IN_DATA0..3  out  32 each  to core data words
- IN_KEY0..3  out  32 each  to core key words
- Krdy  out  1  key-ready pulse
- Drdy  out  1  data-ready pulse
- EN  out  1  core enable
- BSY  in  1  core busy
- OUT_DATA0..3  in  32 each  core result words

Behaviour:
- Reset (async, RSTn=0):
  - all data/key/RES registers = 0; Krdy = Drdy = 0; EN = 0; BUSY = DONE = ERR = 0.
  - internal key_valid = 0; state = IDLE.
  - EN goes 1 on the first CLK edge after RSTn deasserts and stays 1.
- Writes:
  - accepted only in IDLE; the addressed register updates on the next edge.
  - WR_EN while BUSY = 1 is silently dropped.
  - a key-word write clears key_valid.
- IN_DATAn/IN_KEYn are driven directly from the registers and are stable for the whole operation.
- FSM states: IDLE, KREQ, KWAIT, DREQ, DWAIT, CAP.
  - IDLE: on START, if KEY_LOAD = 1 or key_valid = 0, go to KREQ; else go to DREQ.
  - IDLE: START also clears DONE.
  - KREQ: Krdy = 1 for exactly one cycle; next state KWAIT.
  - KWAIT: ignore BSY for BSY_GUARD cycles, then on BSY = 0 set key_valid = 1 and go to DREQ.
  - DREQ: Drdy = 1 for exactly one cycle; next state DWAIT.
  - DWAIT: same guard rule; on BSY = 0 go to CAP.
  - CAP: RESn <= OUT_DATAn, DONE <= 1, return to IDLE.
- Latency: START to DONE = 1 + (KEY path: 1 + guard + key BSY time) + 1 + guard + data BSY time + 1 cycles.
- BUSY = 1 in every state except IDLE.
- RES registers hold their value until the next CAP; not cleared by CLR_DONE.
- Simultaneous events:
  - START while BUSY is ignored.
  - START and WR_EN in the same IDLE cycle: the write lands and the operation uses the new value; the write is registered on the same edge the FSM leaves IDLE, and the core samples only at Krdy/Drdy one cycle later.
  - CLR_DONE on the same cycle as CAP: the set wins.
  - CLR_DONE at any other time clears DONE and ERR.
- Krdy and Drdy are never asserted in the same cycle; neither is asserted in IDLE.
- Reset mid-operation: immediate return to IDLE with all reset values; no pulse is emitted.

Optional Feature:
- Macro: AES_SEQ_TIMEOUT_EN.
- Defined:
  - a 16-bit wait counter runs in KWAIT and DWAIT.
  - reaching TIMEOUT_CYCLES sets ERR = 1, clears key_valid, leaves DONE = 0 and RES unchanged, and returns to IDLE.
  - the counter clears on entry to each wait state.
- Not defined:
  - no counter logic; waits are unbounded; ERR is tied to 0.

Test Plan:
- FIPS-197 vector, with START and KEY_LOAD = 1:
  - key words 3..0 = 00010203, 04050607, 08090a0b, 0c0d0e0f.
  - data words 3..0 = 00112233, 44556677, 8899aabb, ccddeeff.
  - expect DONE = 1 and RES3..0 = 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
  - expect exactly one Krdy pulse, then one Drdy pulse.
- Key reuse:
  - rewrite data only and START with KEY_LOAD = 0.
  - expect no Krdy, one Drdy, correct ciphertext.
  - after a key-word write, START with KEY_LOAD = 0 must still issue Krdy.
- Busy protection:
  - issue WR_EN to addr 0 with value deadbeef, and a second START, while BUSY.
  - expect IN_DATA0 unchanged, one operation only, same RES as vector 1.
- Reset mid-DWAIT:
  - pull RSTn low.
  - expect BUSY/DONE/Krdy/Drdy/EN = 0 and RES = 0 asynchronously.
  - after release, the vector 1 run must still pass.
- CLR_DONE coincident with CAP:
  - expect DONE = 1.
  - CLR_DONE one cycle later gives DONE = 0 with RES retained.
- With AES_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 16:
  - model a core that holds BSY = 1 after Drdy.
  - expect ERR = 1, BUSY = 0 and DONE = 0 after 16 DWAIT cycles.
  - the next START with KEY_LOAD = 0 still issues Krdy.
